// File: rtl/exp_fluxo_dados_param_if.sv
// exp_fluxo_dados_param_if: strobes from the game control unit and status/debug flags back from the datapath.
interface exp_fluxo_dados_param_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    logic                  zeraC, contaC, zeraL, contaL, zeraR, registraR, zeraT, contaT, escreveM;
    logic [DATA_WIDTH-1:0] chaves;
    logic                  chavesIgualMemoria, enderecoIgualLimite, fimC, fimL, fimT, jogada_feita, db_tempo;
    logic [ADDR_WIDTH-1:0] db_contagem, db_limite;
    logic [DATA_WIDTH-1:0] db_chaves, db_memoria;

    modport master (
        output zeraC, contaC, zeraL, contaL, zeraR, registraR, zeraT, contaT, escreveM, chaves,
        input  chavesIgualMemoria, enderecoIgualLimite, fimC, fimL, fimT, jogada_feita, db_tempo,
        input  db_contagem, db_limite, db_chaves, db_memoria
    );

    modport slave (
        input  zeraC, contaC, zeraL, contaL, zeraR, registraR, zeraT, contaT, escreveM, chaves,
        output chavesIgualMemoria, enderecoIgualLimite, fimC, fimL, fimT, jogada_feita, db_tempo,
        output db_contagem, db_limite, db_chaves, db_memoria
    );
endinterface

// File: rtl/exp_fluxo_dados_param.sv
// exp_fluxo_dados_param: parametrised sequence-memory game datapath (counters, key register, sequence memory, edge detector, timeout).
module exp_fluxo_dados_param #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 3000
) (
    input logic                   clock,
    input logic                   reset_n,
    exp_fluxo_dados_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT);

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t f_init();
        for (int i = 0; i < DEPTH; i++) begin
            f_init[i]                 = '0;
            f_init[i][i % DATA_WIDTH] = 1'b1;
        end
    endfunction

    logic [ADDR_WIDTH-1:0] r_cnt, r_lim;
    logic [TW-1:0]         r_tmr;
    logic [DATA_WIDTH-1:0] r_key;
    logic                  r_tecla_ant;
    mem_t                  r_mem = f_init();
    logic [DATA_WIDTH-1:0] w_mem_rd;
    logic                  w_tecla, w_lim_max, w_tmr_max;

    assign w_tecla   = |bus.chaves;
    assign w_lim_max = &r_lim;
    assign w_tmr_max = r_tmr == TW'(TIMEOUT - 1);
    assign w_mem_rd  = r_mem[r_cnt];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_lim       <= '0;
            r_tmr       <= '0;
            r_key       <= '0;
            r_tecla_ant <= 1'b0;
        end else begin
            r_cnt       <= bus.zeraC ? '0 : bus.contaC ? r_cnt + ADDR_WIDTH'(1) : r_cnt;
            r_lim       <= bus.zeraL ? '0 : (bus.contaL && !w_lim_max) ? r_lim + ADDR_WIDTH'(1) : r_lim;
            r_tmr       <= bus.zeraT ? '0 : (bus.contaT && !w_tmr_max) ? r_tmr + TW'(1) : r_tmr;
            r_key       <= bus.zeraR ? '0 : bus.registraR ? bus.chaves : r_key;
            r_tecla_ant <= w_tecla;
        end
    end

    // Memory is not cleared by reset; a write sampled while reset is held is dropped.
    always_ff @(posedge clock) begin
        if (bus.escreveM && reset_n)
            r_mem[r_cnt] <= r_key;
    end

    assign bus.chavesIgualMemoria  = r_key == w_mem_rd;
    assign bus.enderecoIgualLimite = r_cnt == r_lim;
    assign bus.fimC                = &r_cnt;
    assign bus.fimL                = w_lim_max;
    assign bus.fimT                = w_tmr_max;
    assign bus.db_tempo            = w_tmr_max;
    assign bus.jogada_feita        = w_tecla & ~r_tecla_ant;
    assign bus.db_contagem         = r_cnt;
    assign bus.db_limite           = r_lim;
    assign bus.db_chaves           = r_key;
    assign bus.db_memoria          = w_mem_rd;
endmodule

// File: tb/tb_exp_fluxo_dados_param.sv
// tb_exp_fluxo_dados_param: directed scoreboard bench; expectations are queued with the stimulus and popped at each check.
module tb_exp_fluxo_dados_param;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int TO = 10;

    logic clock = 1'b0;
    logic reset_n;

    exp_fluxo_dados_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    exp_fluxo_dados_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input string t, input logic [31:0] e);
        exp_t x;
        x.tag = t;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t x;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_c(input int n);
        bus.contaC = 1'b1;
        repeat (n) tick();
        bus.contaC = 1'b0;
    endtask

    task automatic pulse_l(input int n);
        bus.contaL = 1'b1;
        repeat (n) tick();
        bus.contaL = 1'b0;
    endtask

    task automatic clear_c();
        bus.zeraC = 1'b1;
        tick();
        bus.zeraC = 1'b0;
    endtask

    initial begin
        {bus.zeraC, bus.contaC, bus.zeraL, bus.contaL, bus.zeraR, bus.registraR, bus.zeraT, bus.contaT, bus.escreveM} = '0;
        bus.chaves = '0;
        reset_n    = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        push("rst_cont", 0);  pop_chk(32'(bus.db_contagem));
        push("rst_lim", 0);   pop_chk(32'(bus.db_limite));
        push("rst_eil", 1);   pop_chk(32'(bus.enderecoIgualLimite));
        push("rst_fim", 0);   pop_chk(32'({bus.fimC, bus.fimL, bus.fimT}));
        push("rst_cim", 0);   pop_chk(32'(bus.chavesIgualMemoria));
        push("rst_mem0", 1);  pop_chk(32'(bus.db_memoria));

        bus.chaves = 4'b0001; bus.registraR = 1'b1; tick(); bus.registraR = 1'b0;
        push("load_key", 1);  pop_chk(32'(bus.db_chaves));
        push("cim_a0", 1);    pop_chk(32'(bus.chavesIgualMemoria));
        pulse_c(1);
        push("addr1", 1);     pop_chk(32'(bus.db_contagem));
        push("mem1_dflt", 2); pop_chk(32'(bus.db_memoria));
        push("cim_a1", 0);    pop_chk(32'(bus.chavesIgualMemoria));
        bus.escreveM = 1'b1; tick(); bus.escreveM = 1'b0;
        push("mem1_wr", 1);   pop_chk(32'(bus.db_memoria));
        push("cim_wr", 1);    pop_chk(32'(bus.chavesIgualMemoria));
        push("addr_hold", 1); pop_chk(32'(bus.db_contagem));

        clear_c();
        pulse_c(15);
        push("fimC_15", 1);   pop_chk(32'(bus.fimC));
        push("mem15", 8);     pop_chk(32'(bus.db_memoria));
        pulse_c(1);
        push("wrap_addr", 0); pop_chk(32'(bus.db_contagem));
        push("wrap_fimC", 0); pop_chk(32'(bus.fimC));
        pulse_l(3);
        push("lim3", 3);      pop_chk(32'(bus.db_limite));
        push("eil_a0l3", 0);  pop_chk(32'(bus.enderecoIgualLimite));
        pulse_c(3);
        push("eil_a3l3", 1);  pop_chk(32'(bus.enderecoIgualLimite));
        pulse_l(20);
        push("lim_sat", 15);  pop_chk(32'(bus.db_limite));
        push("fimL", 1);      pop_chk(32'(bus.fimL));
        bus.zeraL = 1'b1; bus.contaL = 1'b1; tick(); {bus.zeraL, bus.contaL} = '0;
        push("zeraL_prio", 0); pop_chk(32'(bus.db_limite));

        // Mid-operation asynchronous reset, with a write held through it
        clear_c(); pulse_c(5); pulse_l(3);
        bus.registraR = 1'b1; bus.chaves = 4'b0110; tick(); bus.registraR = 1'b0;
        bus.zeraT = 1'b1; tick(); bus.zeraT = 1'b0;
        bus.contaT = 1'b1; repeat (4) tick(); bus.contaT = 1'b0;
        push("pre_rst_cont", 5); pop_chk(32'(bus.db_contagem));
        #2 reset_n = 1'b0;
        #1;
        push("arst_cont", 0);  pop_chk(32'(bus.db_contagem));
        push("arst_lim", 0);   pop_chk(32'(bus.db_limite));
        push("arst_key", 0);   pop_chk(32'(bus.db_chaves));
        push("arst_eil", 1);   pop_chk(32'(bus.enderecoIgualLimite));
        push("arst_fimT", 0);  pop_chk(32'(bus.fimT));
        bus.escreveM = 1'b1; tick(); tick(); bus.escreveM = 1'b0;
        reset_n = 1'b1; tick();
        push("rst_wr_lost", 1); pop_chk(32'(bus.db_memoria));

        bus.zeraT = 1'b1; tick(); bus.zeraT = 1'b0;
        bus.contaT = 1'b1;
        repeat (TO - 2) tick();
        push("fimT_early", 0); pop_chk(32'(bus.fimT));
        tick();
        push("fimT_rise", 1);  pop_chk(32'(bus.fimT));
        push("db_tempo", 1);   pop_chk(32'(bus.db_tempo));
        repeat (5) tick();
        push("fimT_hold", 1);  pop_chk(32'(bus.fimT));
        bus.zeraT = 1'b1; tick(); {bus.zeraT, bus.contaT} = '0;
        push("fimT_clear", 0); pop_chk(32'(bus.fimT));

        bus.chaves = 4'b0000; tick();
        bus.chaves = 4'b0100; #1;
        push("edge_rise", 1);  pop_chk(32'(bus.jogada_feita));
        tick();
        push("edge_held1", 0); pop_chk(32'(bus.jogada_feita));
        repeat (4) tick();
        push("edge_held5", 0); pop_chk(32'(bus.jogada_feita));
        bus.chaves = 4'b0010; #1;
        push("edge_change", 0); pop_chk(32'(bus.jogada_feita));
        bus.chaves = 4'b0000; tick();
        bus.chaves = 4'b1000; #1;
        push("edge_again", 1); pop_chk(32'(bus.jogada_feita));
        tick();
        push("edge_drop", 0);  pop_chk(32'(bus.jogada_feita));

        clear_c(); pulse_c(7);
        bus.zeraC = 1'b1; bus.contaC = 1'b1; tick(); {bus.zeraC, bus.contaC} = '0;
        push("zeraC_prio", 0); pop_chk(32'(bus.db_contagem));
        pulse_c(2);
        bus.chaves = 4'b0110; bus.registraR = 1'b1; tick(); bus.registraR = 1'b0;
        bus.escreveM = 1'b1; bus.contaC = 1'b1; tick(); {bus.escreveM, bus.contaC} = '0;
        push("wr_inc_addr", 3); pop_chk(32'(bus.db_contagem));
        push("mem3_untouched", 8); pop_chk(32'(bus.db_memoria));
        clear_c(); pulse_c(2);
        push("mem2_written", 6); pop_chk(32'(bus.db_memoria));
        push("cim_a2", 1);     pop_chk(32'(bus.chavesIgualMemoria));
        bus.zeraR = 1'b1; bus.registraR = 1'b1; tick(); {bus.zeraR, bus.registraR} = '0;
        push("zeraR_prio", 0); pop_chk(32'(bus.db_chaves));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exp_fluxo_dados_param.md
# exp_fluxo_dados_param

Parametrised datapath for the sequence-memory game, the successor to the fixed 4-bit/16-address datapath. It sits under the game's control unit, which drives only clear/count/load/write strobes and reads back status flags. Compared with the fixed datapath it adds:
- configurable key width and memory depth;
- a round-limit counter;
- a writable sequence memory;
- a key-press edge detector;
- a timeout counter.

## Interface
- DATA_WIDTH, 4: width of keys, memory words and key register
- ADDR_WIDTH, 4: address width; DEPTH = 2**ADDR_WIDTH
- TIMEOUT, 3000: cycles counted before fimT asserts (≥2)
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low; clears every register listed below (not the memory array)
- zeraC, contaC  in  1  address counter: sync clear / increment
- zeraL, contaL  in  1  limit (round) counter: sync clear / increment
- zeraR, registraR  in  1  key register: sync clear / load
- zeraT, contaT  in  1  timeout counter: sync clear / increment
- escreveM  in  1  write key register contents into memory at current address
- chaves  in  DATA_WIDTH  player keys (already synchronised upstream)
- chavesIgualMemoria  out  1  key register == memory word at current address
- enderecoIgualLimite  out  1  address counter == limit counter
- fimC  out  1  address counter == DEPTH-1
- fimL  out  1  limit counter == DEPTH-1
- fimT  out  1  timeout counter == TIMEOUT-1
- jogada_feita  out  1  key-press edge detected
- db_contagem, db_limite  out  ADDR_WIDTH  debug: address / limit counter
- db_chaves, db_memoria  out  DATA_WIDTH  debug: key register / memory read data
- db_tempo  out  1  debug: copy of fimT

## Operation
- **Address counter:** zeraC has priority over contaC. Increment wraps DEPTH-1 → 0.
- **Limit counter:** zeraL has priority over contaL. Saturates at DEPTH-1; contaL there is ignored.
- **Timeout counter:** zeraT has priority over contaT. Saturates at TIMEOUT-1; fimT stays high until zeraT or reset. Counter width is $clog2(TIMEOUT).
- **Key register:** zeraR has priority over registraR. Loads chaves.
- **Memory, read:** DEPTH × DATA_WIDTH, asynchronous read at the address counter value.
- **Memory, write:** synchronous, at the edge where escreveM=1. Data is the key-register value before that edge. Address is the address-counter value before that edge, even if contaC is also asserted.
- **Memory, initial contents:** word i = one-hot bit (i mod DATA_WIDTH), i.e. 0001, 0010, 0100, 1000, 0001… for DATA_WIDTH=4. reset_n does not alter the memory.
- **Comparators and flags:** purely combinational from current register/memory state.
- **Edge detector:** register tecla_ant <= |chaves. jogada_feita = (|chaves) & ~tecla_ant, so it is high from the moment any key goes nonzero until the next rising edge. A held key produces exactly one pulse. Changing from one nonzero value to another produces no pulse.
- **Reset values:** all counters, the key register and tecla_ant = 0. After reset:
  - fimC=0, fimL=0, fimT=0
  - enderecoIgualLimite=1
  - chavesIgualMemoria = (memory word 0 == 0), i.e. 0 with default contents
- **Reset mid-operation:**
  - reset_n low clears registers immediately, regardless of the clock.
  - An escreveM coincident with reset assertion is lost.
  - Deassertion is synchronous to the control unit's idle strobes; no extra requirement.

## Timing
- Counter, register and memory updates are visible one clock edge after the strobe is sampled high.
- chavesIgualMemoria is valid in the same cycle as any address or key-register change (zero-cycle combinational path).
- A read at an address written on edge N returns the new data from edge N onward.
- Simultaneous strobes on different registers are independent; all act on the same edge.
- TIMEOUT-1 edges with contaT=1 after zeraT are required to raise fimT.

## Test plan
- **Reset:** reset_n=0 mid-count (address=5, limit=3) → immediately all db_* counters 0, enderecoIgualLimite=1, fimT=0.
- **Compare, then write:**
  - Address 0, chaves=0001, registraR → chavesIgualMemoria=1.
  - contaC → address 1, chaves register still 0001 vs memory 0010 → chavesIgualMemoria=0.
  - escreveM → memory[1]=0001, chavesIgualMemoria=1.
- **Address wrap and limit:**
  - 15 contaC pulses → fimC=1.
  - One more pulse → address 0, fimC=0.
  - contaL ×3 → limit 3; address 3 gives enderecoIgualLimite=1.
  - contaL ×20 → limit saturates at 15, fimL=1.
- **Timeout** (TIMEOUT=10): zeraT then contaT held → fimT rises after exactly 9 edges and holds; zeraT → fimT=0 next edge.
- **Edge detector:**
  - chaves 0000 → 0100 held 5 cycles → jogada_feita high for only the first partial cycle.
  - 0100 → 0010 → no pulse.
  - 0000 then 1000 → pulse.
- **Priority:** zeraC=contaC=1 at address 7 → address 0; escreveM with contaC at address 2 → write lands at address 2, counter becomes 3.
